ps2_keycode_decoder: RTL and testbench
======================================

// Module: ps2_keycode_decoder
// PURPOSE
//  Consumes raw PS/2 set-2 scan codes from the PS/2 interface and turns them into ASCII.
//  Tracks make/break/extended prefixes and the shift, ctrl and caps-lock state.
//  Queues decoded characters in a show-ahead FIFO for the host-side register interface.
//  Sits directly downstream of the PS/2 keycode stage.
// PARAMETERS
//  FIFO_DEPTH  16  character FIFO entries; must be a power of 2, >= 2
//  FIFO_AW     4   log2(FIFO_DEPTH)
// PORTS
//  CLK_50      in   1  system clock
//  RESET       in   1  synchronous, active-high reset
//  KEYCODE_IN  in   8  scan-code byte; valid only when KEYCODE_RDY=1
//  KEYCODE_RDY in   1  single-cycle strobe: one new byte on KEYCODE_IN
//  RD_REQ      in   1  host pops the FIFO head; ignored while DATA_VALID=0
//  ASCII_OUT   out  8  FIFO head; meaningful only while DATA_VALID=1
//  DATA_VALID  out  1  FIFO not empty
//  FIFO_FULL   out  1  FIFO holds FIFO_DEPTH entries
//  OVERFLOW    out  1  sticky; set when a character is dropped because the FIFO is full
//  MOD_STATUS  out  3  {caps_lock, ctrl, shift}, registered
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; FIFO is empty.
//   - Modifiers and caps_held are cleared; FSM returns to IDLE.
//   - A reset mid-sequence (e.g. after E0 F0) discards the partial sequence.
//  Prefix FSM (advances only on KEYCODE_RDY):
//   - IDLE: F0 -> BRK; E0 -> EXT; AA/FA/FE/EE/00/FF -> IDLE, ignored; other -> decode make, IDLE.
//   - BRK: F0 -> BRK; E0 -> EXT; other -> decode break, IDLE.
//   - EXT: F0 -> EXT_BRK; E0 -> EXT; other -> decode extended make, IDLE.
//   - EXT_BRK: F0 -> EXT_BRK; E0 -> EXT; other -> decode extended break, IDLE.
//  Modifier codes:
//   - shift: 12, 59. shift = L or R held; separate L/R flags.
//   - ctrl: 14, E0 14. ctrl = L or R held.
//   - caps: 58. On make, caps_lock toggles only if caps_held=0, then caps_held is set.
//     On break, caps_held clears. Typematic repeats therefore do not re-toggle.
//   - E0 12 and E0 59 (fake shifts) are ignored.
//   - Modifier codes never enqueue a character.
//  Character map (make only; breaks never enqueue):
//   - letters: 1C=a 32=b 21=c 23=d 24=e 2B=f 34=g 33=h 43=i 3B=j 42=k 4B=l 3A=m
//     31=n 44=o 4D=p 15=q 2D=r 1B=s 2C=t 3C=u 2A=v 1D=w 22=x 35=y 1A=z
//   - digits: 16..45 = '1'..'0' (16,1E,26,25,2E,36,3D,3E,46,45); shifted -> !@#$%^&*()
//   - 29=20h, 5A=0Dh, E0 5A=0Dh, 66=08h, 76=1Bh, 0D=09h
//   - letter case: upper when shift XOR caps_lock. ctrl+letter -> (upper & 1Fh); ctrl has priority.
//   - Any other make code, or any other extended code: dropped. The FSM still returns to IDLE.
//  Latency:
//   - A strobe in cycle N registers the decode in N+1 and writes the FIFO at the end of N+1.
//   - The character is visible at ASCII_OUT with DATA_VALID=1 in N+2 if the FIFO was empty.
//   - MOD_STATUS updates in N+1.
//   - Back-to-back strobes every cycle are sustained.
//  FIFO:
//   - Show-ahead. RD_REQ with DATA_VALID pops the head; the next entry appears the following cycle.
//   - Write and pop in the same cycle when full: both are accepted; the FIFO stays full.
//   - Write when full with no pop: character dropped, OVERFLOW <= 1; OVERFLOW clears only on RESET.
//   - Pointers wrap modulo FIFO_DEPTH; occupancy counter is FIFO_AW+1 bits.
// TESTING
//  - RESET, then 1C -> ASCII_OUT=61h, DATA_VALID=1 at N+2; F0 1C -> no new entry.
//  - 12, 1C, F0 12, 1C -> entries 41h, 61h; MOD_STATUS=001b after 12, 000b after F0 12.
//  - 58, 58, F0 58, 1C -> caps_lock=1 (single toggle), entry 41h; 12, 1C -> 61h.
//  - E0 14, 21 -> entry 03h; E0 F0 14 clears ctrl; E0 5A -> 0Dh; E0 75 -> nothing.
//  - 17 distinct makes, no reads (FIFO_DEPTH=16) -> FIFO_FULL=1, OVERFLOW=1, first 16 read back in order.
//  - RESET asserted between E0 and F0 -> next 1C yields 61h; FIFO and MOD_STATUS cleared.

Source files
------------

// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder: prefix FSM, modifier tracking and a
// show-ahead character FIFO for the host register interface.
`timescale 1ns/1ps
module ps2_keycode_decoder #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic       CLK_50,
  input  logic       RESET,
  input  logic [7:0] KEYCODE_IN,
  input  logic       KEYCODE_RDY,
  input  logic       RD_REQ,
  output logic [7:0] ASCII_OUT,
  output logic       DATA_VALID,
  output logic       FIFO_FULL,
  output logic       OVERFLOW,
  output logic [2:0] MOD_STATUS
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_e;

  state_e state_q, state_d;

  logic key_make, key_brk, key_ext;

  logic lshift_q, lshift_d;
  logic rshift_q, rshift_d;
  logic lctrl_q, lctrl_d;
  logic rctrl_q, rctrl_d;
  logic caps_lock_q, caps_lock_d;
  logic caps_held_q, caps_held_d;
  logic [2:0] mod_q, mod_d;

  logic       dec_vld_q, dec_vld_d;
  logic [7:0] dec_chr_q, dec_chr_d;

  logic       shift_now, ctrl_now, upper_now;
  logic [7:0] letter_lc;
  logic [15:0] digit_pair;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               fifo_empty, fifo_full, wr_en, rd_en;

  // Lowercase ASCII for a letter make code, 0 when the code is not a letter.
  function automatic logic [7:0] letter_of(input logic [7:0] c);
    case (c)
      8'h1C: letter_of = 8'h61;  8'h32: letter_of = 8'h62;
      8'h21: letter_of = 8'h63;  8'h23: letter_of = 8'h64;
      8'h24: letter_of = 8'h65;  8'h2B: letter_of = 8'h66;
      8'h34: letter_of = 8'h67;  8'h33: letter_of = 8'h68;
      8'h43: letter_of = 8'h69;  8'h3B: letter_of = 8'h6A;
      8'h42: letter_of = 8'h6B;  8'h4B: letter_of = 8'h6C;
      8'h3A: letter_of = 8'h6D;  8'h31: letter_of = 8'h6E;
      8'h44: letter_of = 8'h6F;  8'h4D: letter_of = 8'h70;
      8'h15: letter_of = 8'h71;  8'h2D: letter_of = 8'h72;
      8'h1B: letter_of = 8'h73;  8'h2C: letter_of = 8'h74;
      8'h3C: letter_of = 8'h75;  8'h2A: letter_of = 8'h76;
      8'h1D: letter_of = 8'h77;  8'h22: letter_of = 8'h78;
      8'h35: letter_of = 8'h79;  8'h1A: letter_of = 8'h7A;
      default: letter_of = 8'h00;
    endcase
  endfunction

  // {shifted, unshifted} ASCII for a digit-row code, 0 when not a digit.
  function automatic logic [15:0] digit_of(input logic [7:0] c);
    case (c)
      8'h16: digit_of = {8'h21, 8'h31};
      8'h1E: digit_of = {8'h40, 8'h32};
      8'h26: digit_of = {8'h23, 8'h33};
      8'h25: digit_of = {8'h24, 8'h34};
      8'h2E: digit_of = {8'h25, 8'h35};
      8'h36: digit_of = {8'h5E, 8'h36};
      8'h3D: digit_of = {8'h26, 8'h37};
      8'h3E: digit_of = {8'h2A, 8'h38};
      8'h46: digit_of = {8'h28, 8'h39};
      8'h45: digit_of = {8'h29, 8'h30};
      default: digit_of = 16'h0000;
    endcase
  endfunction

  // Prefix tracking: classifies the current byte as make/break, plain/extended.
  always_comb begin
    state_d  = state_q;
    key_make = 1'b0;
    key_brk  = 1'b0;
    key_ext  = 1'b0;
    if (KEYCODE_RDY) begin
      unique case (state_q)
        S_IDLE: begin
          if (KEYCODE_IN == 8'hF0) begin
            state_d = S_BRK;
          end else if (KEYCODE_IN == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            state_d = S_IDLE;
            key_make = !(KEYCODE_IN inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF});
          end
        end
        S_BRK: begin
          if (KEYCODE_IN == 8'hF0) begin
            state_d = S_BRK;
          end else if (KEYCODE_IN == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            state_d = S_IDLE;
            key_brk = 1'b1;
          end
        end
        S_EXT: begin
          if (KEYCODE_IN == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (KEYCODE_IN == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            state_d  = S_IDLE;
            key_make = 1'b1;
            key_ext  = 1'b1;
          end
        end
        S_EXT_BRK: begin
          if (KEYCODE_IN == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (KEYCODE_IN == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            state_d = S_IDLE;
            key_brk = 1'b1;
            key_ext = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Modifier update and character translation for the classified byte.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    caps_lock_d = caps_lock_q;
    caps_held_d = caps_held_q;
    dec_vld_d   = 1'b0;
    dec_chr_d   = '0;
    shift_now   = lshift_q | rshift_q;
    ctrl_now    = lctrl_q | rctrl_q;
    upper_now   = shift_now ^ caps_lock_q;
    letter_lc   = letter_of(KEYCODE_IN);
    digit_pair  = digit_of(KEYCODE_IN);

    if (key_ext) begin
      if (KEYCODE_IN == 8'h14) begin
        rctrl_d = key_make;
      end else if (KEYCODE_IN == 8'h5A && key_make) begin
        dec_vld_d = 1'b1;
        dec_chr_d = 8'h0D;
      end
    end else if (key_make || key_brk) begin
      case (KEYCODE_IN)
        8'h12: lshift_d = key_make;
        8'h59: rshift_d = key_make;
        8'h14: lctrl_d  = key_make;
        8'h58: begin
          // Held-key latch stops typematic repeats from re-toggling caps lock.
          if (key_make) begin
            if (!caps_held_q) caps_lock_d = ~caps_lock_q;
            caps_held_d = 1'b1;
          end else begin
            caps_held_d = 1'b0;
          end
        end
        default: begin
          if (key_make) begin
            if (letter_lc != 8'h00) begin
              dec_vld_d = 1'b1;
              if (ctrl_now)       dec_chr_d = letter_lc & 8'h1F;
              else if (upper_now) dec_chr_d = letter_lc & 8'hDF;
              else                dec_chr_d = letter_lc;
            end else if (digit_pair != 16'h0000) begin
              dec_vld_d = 1'b1;
              dec_chr_d = shift_now ? digit_pair[15:8] : digit_pair[7:0];
            end else begin
              case (KEYCODE_IN)
                8'h29: begin dec_vld_d = 1'b1; dec_chr_d = 8'h20; end
                8'h5A: begin dec_vld_d = 1'b1; dec_chr_d = 8'h0D; end
                8'h66: begin dec_vld_d = 1'b1; dec_chr_d = 8'h08; end
                8'h76: begin dec_vld_d = 1'b1; dec_chr_d = 8'h1B; end
                8'h0D: begin dec_vld_d = 1'b1; dec_chr_d = 8'h09; end
                default: ;
              endcase
            end
          end
        end
      endcase
    end

    mod_d = {caps_lock_d, lctrl_d | rctrl_d, lshift_d | rshift_d};
  end

  // Character FIFO control; a write while full is accepted only alongside a pop.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == (FIFO_AW+1)'(FIFO_DEPTH));
    rd_en      = RD_REQ & ~fifo_empty;
    wr_en      = dec_vld_q & (~fifo_full | rd_en);
    wr_ptr_d   = wr_en ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    cnt_d      = cnt_q;
    if (wr_en && !rd_en)      cnt_d = cnt_q + (FIFO_AW+1)'(1);
    else if (!wr_en && rd_en) cnt_d = cnt_q - (FIFO_AW+1)'(1);
    ovf_d      = ovf_q | (dec_vld_q & ~wr_en);
  end

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_lock_q <= 1'b0;
      caps_held_q <= 1'b0;
      mod_q       <= '0;
      dec_vld_q   <= 1'b0;
      dec_chr_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      caps_lock_q <= caps_lock_d;
      caps_held_q <= caps_held_d;
      mod_q       <= mod_d;
      dec_vld_q   <= dec_vld_d;
      dec_chr_q   <= dec_chr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (wr_en) mem_q[wr_ptr_q] <= dec_chr_q;
  end

  always_comb begin
    ASCII_OUT  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    DATA_VALID = ~fifo_empty;
    FIFO_FULL  = fifo_full;
    OVERFLOW   = ovf_q;
    MOD_STATUS = mod_q;
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Bench for ps2_keycode_decoder: vector table, FIFO/reset corner sequences and
// randomized scan-code streams checked against a behavioural keyboard model.
`timescale 1ns/1ps
module tb_ps2_keycode_decoder;

  logic       CLK_50 = 1'b0;
  logic       RESET;
  logic [7:0] KEYCODE_IN;
  logic       KEYCODE_RDY;
  logic       RD_REQ;
  logic [7:0] ASCII_OUT;
  logic       DATA_VALID;
  logic       FIFO_FULL;
  logic       OVERFLOW;
  logic [2:0] MOD_STATUS;

  always #10 CLK_50 = ~CLK_50;

  ps2_keycode_decoder #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .CLK_50(CLK_50), .RESET(RESET), .KEYCODE_IN(KEYCODE_IN),
    .KEYCODE_RDY(KEYCODE_RDY), .RD_REQ(RD_REQ), .ASCII_OUT(ASCII_OUT),
    .DATA_VALID(DATA_VALID), .FIFO_FULL(FIFO_FULL), .OVERFLOW(OVERFLOW),
    .MOD_STATUS(MOD_STATUS)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // All tasks start and end on a falling clock edge.
  task automatic strobe(input logic [7:0] c);
    KEYCODE_IN = c; KEYCODE_RDY = 1'b1;
    @(negedge CLK_50);
    KEYCODE_RDY = 1'b0;
  endtask
  task automatic idle(input int unsigned n);
    repeat (n) @(negedge CLK_50);
  endtask
  task automatic pop();
    RD_REQ = 1'b1;
    @(negedge CLK_50);
    RD_REQ = 1'b0;
  endtask
  task automatic do_reset();
    RESET = 1'b1; KEYCODE_RDY = 1'b0; RD_REQ = 1'b0;
    @(negedge CLK_50);
    RESET = 1'b0;
  endtask

  // ---------------- keyboard reference model ----------------
  logic [7:0] letter_codes [26];
  logic [7:0] digit_codes  [10];
  logic [7:0] special_codes [5];
  logic [7:0] special_chars [5];
  string dig_plain = "1234567890";
  string dig_shift = "!@#$%^&*()";
  bit m_brk, m_ext, m_ls, m_rs, m_lc, m_rc, m_caps, m_held;
  logic [7:0] exp_q [$];

  task automatic model_reset();
    {m_brk, m_ext, m_ls, m_rs, m_lc, m_rc, m_caps, m_held} = '0;
    exp_q.delete();
  endtask

  function automatic logic [2:0] model_mod();
    return {m_caps, m_lc | m_rc, m_ls | m_rs};
  endfunction

  task automatic model_byte(input logic [7:0] c);
    bit make;
    if (c == 8'hF0) begin m_brk = 1'b1; return; end
    if (c == 8'hE0) begin m_ext = 1'b1; m_brk = 1'b0; return; end
    make = !m_brk;
    if (!m_brk && !m_ext && (c inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
    end else if (m_ext) begin
      if (c == 8'h14) m_rc = make;
      else if (c == 8'h5A && make) exp_q.push_back(8'h0D);
    end else if (c == 8'h12) m_ls = make;
    else if (c == 8'h59) m_rs = make;
    else if (c == 8'h14) m_lc = make;
    else if (c == 8'h58) begin
      if (make) begin
        if (!m_held) m_caps = !m_caps;
        m_held = 1'b1;
      end else m_held = 1'b0;
    end else if (make) begin
      for (int i = 0; i < 26; i++)
        if (letter_codes[i] == c) begin
          if (m_lc || m_rc)                exp_q.push_back(8'(i + 1));
          else if ((m_ls || m_rs) != m_caps) exp_q.push_back(8'(65 + i));
          else                              exp_q.push_back(8'(97 + i));
        end
      for (int i = 0; i < 10; i++)
        if (digit_codes[i] == c)
          exp_q.push_back((m_ls || m_rs) ? dig_shift[i] : dig_plain[i]);
      for (int i = 0; i < 5; i++)
        if (special_codes[i] == c) exp_q.push_back(special_chars[i]);
    end
    m_brk = 1'b0; m_ext = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    int unsigned r = $urandom_range(0, 99);
    logic [7:0] mods [4] = '{8'h12, 8'h59, 8'h14, 8'h58};
    if (r < 12) return 8'hF0;
    if (r < 20) return 8'hE0;
    if (r < 36) return mods[$urandom_range(0, 3)];
    if (r < 62) return letter_codes[$urandom_range(0, 25)];
    if (r < 74) return digit_codes[$urandom_range(0, 9)];
    if (r < 82) return special_codes[$urandom_range(0, 4)];
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    int unsigned n;
    logic [31:0] codes;   // first byte in the top byte
    bit          has;
    logic [7:0]  ch;
    logic [2:0]  mod;
  } vec_t;

  function automatic vec_t mk(string nm, int unsigned n, logic [31:0] codes,
                              bit has, logic [7:0] ch, logic [2:0] mod);
    vec_t v;
    v.name = nm; v.n = n; v.codes = codes; v.has = has; v.ch = ch; v.mod = mod;
    return v;
  endfunction

  vec_t vecs [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    int unsigned nb, nexp;
    RESET = 1'b1; KEYCODE_IN = '0; KEYCODE_RDY = 1'b0; RD_REQ = 1'b0;

    letter_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digit_codes   = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    special_codes = '{8'h29, 8'h5A, 8'h66, 8'h76, 8'h0D};
    special_chars = '{8'h20, 8'h0D, 8'h08, 8'h1B, 8'h09};

    vecs.push_back(mk("make_a",        1, 32'h1C000000, 1, 8'h61, 3'b000));
    vecs.push_back(mk("break_a",       2, 32'hF01C0000, 0, 8'h00, 3'b000));
    vecs.push_back(mk("lshift_make",   1, 32'h12000000, 0, 8'h00, 3'b001));
    vecs.push_back(mk("shift_a",       1, 32'h1C000000, 1, 8'h41, 3'b001));
    vecs.push_back(mk("lshift_break",  2, 32'hF0120000, 0, 8'h00, 3'b000));
    vecs.push_back(mk("plain_a",       1, 32'h1C000000, 1, 8'h61, 3'b000));
    vecs.push_back(mk("caps_make",     1, 32'h58000000, 0, 8'h00, 3'b100));
    vecs.push_back(mk("caps_repeat",   1, 32'h58000000, 0, 8'h00, 3'b100));
    vecs.push_back(mk("caps_break",    2, 32'hF0580000, 0, 8'h00, 3'b100));
    vecs.push_back(mk("caps_a",        1, 32'h1C000000, 1, 8'h41, 3'b100));
    vecs.push_back(mk("caps_shift_a",  2, 32'h121C0000, 1, 8'h61, 3'b101));
    vecs.push_back(mk("shift_release", 2, 32'hF0120000, 0, 8'h00, 3'b100));
    vecs.push_back(mk("caps_off",      3, 32'h58F05800, 0, 8'h00, 3'b000));
    vecs.push_back(mk("rctrl_make",    2, 32'hE0140000, 0, 8'h00, 3'b010));
    vecs.push_back(mk("ctrl_c",        1, 32'h21000000, 1, 8'h03, 3'b010));
    vecs.push_back(mk("rctrl_break",   3, 32'hE0F01400, 0, 8'h00, 3'b000));
    vecs.push_back(mk("ext_enter",     2, 32'hE05A0000, 1, 8'h0D, 3'b000));
    vecs.push_back(mk("ext_unknown",   2, 32'hE0750000, 0, 8'h00, 3'b000));
    vecs.push_back(mk("rshift_1",      2, 32'h59160000, 1, 8'h21, 3'b001));
    vecs.push_back(mk("rshift_rel_0",  3, 32'hF0594500, 1, 8'h30, 3'b000));
    vecs.push_back(mk("space",         1, 32'h29000000, 1, 8'h20, 3'b000));
    vecs.push_back(mk("fake_shift",    2, 32'hE0120000, 0, 8'h00, 3'b000));
    vecs.push_back(mk("lctrl_z",       2, 32'h141A0000, 1, 8'h1A, 3'b010));
    vecs.push_back(mk("ctrl_rel_bksp", 3, 32'hF0146600, 1, 8'h08, 3'b000));
    vecs.push_back(mk("ignored_codes", 4, 32'hAAFA00FF, 0, 8'h00, 3'b000));
    vecs.push_back(mk("esc",           1, 32'h76000000, 1, 8'h1B, 3'b000));
    vecs.push_back(mk("tab",           1, 32'h0D000000, 1, 8'h09, 3'b000));
    vecs.push_back(mk("double_f0",     3, 32'hF0F01C00, 0, 8'h00, 3'b000));
    vecs.push_back(mk("double_e0",     3, 32'hE0E05A00, 1, 8'h0D, 3'b000));
    vecs.push_back(mk("brk_then_e0",   3, 32'hF0E05A00, 1, 8'h0D, 3'b000));
    vecs.push_back(mk("unmapped",      1, 32'h0E000000, 0, 8'h00, 3'b000));
    vecs.push_back(mk("shift_2",       2, 32'h121E0000, 1, 8'h40, 3'b001));
    vecs.push_back(mk("shift_rel2",    2, 32'hF0120000, 0, 8'h00, 3'b000));
    vecs.push_back(mk("caps_ctrl",     4, 32'h58F05814, 0, 8'h00, 3'b110));
    vecs.push_back(mk("caps_ctrl_b",   1, 32'h32000000, 1, 8'h02, 3'b110));
    vecs.push_back(mk("ctrl_release",  2, 32'hF0140000, 0, 8'h00, 3'b100));
    vecs.push_back(mk("caps_off2",     3, 32'h58F05800, 0, 8'h00, 3'b000));

    repeat (3) @(negedge CLK_50);
    RESET = 1'b0;
    check("reset_ascii", 32'(ASCII_OUT), 32'h0);
    check("reset_valid", 32'(DATA_VALID), 32'h0);
    check("reset_full",  32'(FIFO_FULL), 32'h0);
    check("reset_ovf",   32'(OVERFLOW), 32'h0);
    check("reset_mod",   32'(MOD_STATUS), 32'h0);

    // First-character latency: not valid in N+1, valid in N+2.
    strobe(8'h1C);
    check("lat_n1_valid", 32'(DATA_VALID), 32'h0);
    idle(1);
    check("lat_n2_valid", 32'(DATA_VALID), 32'h1);
    check("lat_n2_ascii", 32'(ASCII_OUT), 32'h61);
    pop();
    check("lat_popped", 32'(DATA_VALID), 32'h0);

    foreach (vecs[i]) begin
      for (int unsigned k = 0; k < vecs[i].n; k++)
        strobe(vecs[i].codes[31 - 8*k -: 8]);
      idle(1);
      check({vecs[i].name, "_valid"}, 32'(DATA_VALID), 32'(vecs[i].has));
      if (vecs[i].has) begin
        check({vecs[i].name, "_ascii"}, 32'(ASCII_OUT), 32'(vecs[i].ch));
        pop();
      end
      check({vecs[i].name, "_mod"}, 32'(MOD_STATUS), 32'(vecs[i].mod));
      check({vecs[i].name, "_empty"}, 32'(DATA_VALID), 32'h0);
    end

    // 17 back-to-back makes with no reads: the last one overflows.
    do_reset();
    for (int i = 0; i < 17; i++) strobe(letter_codes[i]);
    idle(1);
    check("burst_full", 32'(FIFO_FULL), 32'h1);
    check("burst_ovf",  32'(OVERFLOW), 32'h1);
    for (int i = 0; i < 16; i++) begin
      check("burst_valid", 32'(DATA_VALID), 32'h1);
      check("burst_order", 32'(ASCII_OUT), 32'(97 + i));
      pop();
    end
    check("burst_drained", 32'(DATA_VALID), 32'h0);
    check("burst_not_full", 32'(FIFO_FULL), 32'h0);
    check("burst_ovf_sticky", 32'(OVERFLOW), 32'h1);

    // Write and pop in the same cycle while full.
    do_reset();
    check("ovf_cleared", 32'(OVERFLOW), 32'h0);
    for (int i = 0; i < 16; i++) strobe(letter_codes[i]);
    idle(1);
    check("fill_full", 32'(FIFO_FULL), 32'h1);
    check("fill_no_ovf", 32'(OVERFLOW), 32'h0);
    strobe(8'h22);
    pop();
    idle(1);
    check("wrpop_full", 32'(FIFO_FULL), 32'h1);
    check("wrpop_no_ovf", 32'(OVERFLOW), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      check("wrpop_order", 32'(ASCII_OUT), (i == 16) ? 32'h78 : 32'(97 + i));
      pop();
    end
    check("wrpop_drained", 32'(DATA_VALID), 32'h0);

    // Reset in the middle of an E0 F0 sequence.
    do_reset();
    strobe(8'h58); strobe(8'h12); strobe(8'h1C); strobe(8'hE0); strobe(8'hF0);
    do_reset();
    check("midrst_valid", 32'(DATA_VALID), 32'h0);
    check("midrst_mod",   32'(MOD_STATUS), 32'h0);
    strobe(8'h1C);
    idle(1);
    check("midrst_valid2", 32'(DATA_VALID), 32'h1);
    check("midrst_ascii",  32'(ASCII_OUT), 32'h61);
    pop();

    // Randomized scan-code streams against the keyboard model.
    do_reset();
    model_reset();
    for (int b = 0; b < 40; b++) begin
      nb = 0;
      while (exp_q.size() < 10 && nb < 30) begin
        e = pick();
        model_byte(e);
        strobe(e);
        nb++;
        idle($urandom_range(0, 2));
      end
      idle(2);
      check("rand_mod", 32'(MOD_STATUS), 32'(model_mod()));
      nexp = exp_q.size();
      for (int unsigned k = 0; k < nexp; k++) begin
        e = exp_q.pop_front();
        check("rand_valid", 32'(DATA_VALID), 32'h1);
        check("rand_ascii", 32'(ASCII_OUT), 32'(e));
        pop();
      end
      check("rand_empty", 32'(DATA_VALID), 32'h0);
    end
    check("rand_no_ovf", 32'(OVERFLOW), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
